mem_port_arbiter: RTL and testbench

- Shares one byte-wide MMU port between two requesters: the instruction fetch path (opcode buffer) and the data load/store path of the execute stage.
- Runs a single-outstanding-transaction FSM: arbitrate, issue a one-cycle request, wait on MMU busy, return data with a one-cycle ack.
- Sits between the dataflow core and the MMU port, so the MMU's second port can be freed or dropped.

---
 rtl/mem_port_arbiter_pkg.sv | 6 +
 rtl/mem_port_arbiter_if.sv | 28 ++
 rtl/mem_port_arbiter_pick.sv | 27 ++
 rtl/mem_port_arbiter.sv | 75 +++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: FSM state and owner encodings shared by mem_port_arbiter and its arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and MMU port signals of the shared-port arbiter
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 8);
  logic f_req;
  logic [ADDR_W-1:0] f_addr;
  logic f_ack;
  logic [DATA_W-1:0] f_rdata;
  logic d_req;
  logic d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic mem_request;
  logic [DATA_W-1:0] mem_rdata;
  logic mem_busy;
  logic owner;
  modport slave (
    input f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_busy,
    output f_ack, f_rdata, d_ack, d_rdata, mem_addr, mem_we, mem_wdata, mem_request, owner
  );
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_busy,
    input f_ack, f_rdata, d_ack, d_rdata, mem_addr, mem_we, mem_wdata, mem_request, owner
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: fetch/data winner select; MEM_ARB_STARVE_GUARD_EN adds a fetch starvation guard
module mem_arb_pick import mem_arb_pkg::*; #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_i,
  input  logic f_req_i,
  input  logic d_req_i,
  output logic win_o
);
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic starve;
  assign starve = cnt_q == CW'(STARVE_LIMIT);
  assign win_o = d_req_i && !(f_req_i && starve) ? OWN_DATA : OWN_FETCH;
  // count data wins that leave a fetch waiting; any fetch grant clears the count
  always_comb cnt_d = !arb_i ? cnt_q : win_o == OWN_FETCH ? '0 : f_req_i && !starve ? cnt_q + 1'b1 : cnt_q;
  // starvation counter register
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
`else
  logic unused;
  assign unused = ^{clk, reset, arb_i, f_req_i};
  assign win_o = d_req_i ? OWN_DATA : OWN_FETCH;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-outstanding arbiter sharing a byte MMU port between fetch and data; MEM_ARB_STARVE_GUARD_EN enables the fetch starvation guard
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic we_q, we_d, owner_q, owner_d;
  logic arb, win, done, active;
  assign arb = state_q == IDLE && (bus.f_req || bus.d_req);
  assign done = state_q == WAIT && !bus.mem_busy;
  assign active = state_q != IDLE;
  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk(clk),
    .reset(reset),
    .arb_i(arb),
    .f_req_i(bus.f_req),
    .d_req_i(bus.d_req),
    .win_o(win)
  );
  // transaction sequence: IDLE -> ISSUE -> WAIT until MMU idle -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = arb ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = bus.mem_busy ? WAIT : RESP;
      default: state_d = IDLE;
    endcase
  end
  // latch the winner's request at arbitration; capture read data as the MMU finishes
  always_comb begin
    addr_d = arb ? (win ? bus.d_addr : bus.f_addr) : addr_q;
    we_d = arb ? win && bus.d_we : we_q;
    wdata_d = arb ? (win ? bus.d_wdata : '0) : wdata_q;
    owner_d = arb ? win : owner_q;
    f_rdata_d = done && owner_q == OWN_FETCH ? bus.mem_rdata : f_rdata_q;
    d_rdata_d = done && owner_q == OWN_DATA && !we_q ? bus.mem_rdata : d_rdata_q;
  end
  // state, request latch and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      owner_q <= OWN_FETCH;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  assign bus.mem_request = state_q == ISSUE;
  assign bus.mem_addr = active ? addr_q : '0;
  assign bus.mem_we = active && we_q;
  assign bus.mem_wdata = active ? wdata_q : '0;
  assign bus.f_ack = state_q == RESP && owner_q == OWN_FETCH;
  assign bus.d_ack = state_q == RESP && owner_q == OWN_DATA;
  assign bus.f_rdata = f_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.owner = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, corner sequences and a random run against a transaction-level model
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit SG = 1'b1;
`else
  localparam bit SG = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(8)) bus ();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int cur_lat = 0;
  int bcnt = 0;
  logic [7:0] rd_val = 8'h00;
  int iss_cnt, iss_cyc, fa_cnt, da_cnt;
  logic [31:0] iss_addr;
  logic [7:0] iss_wd;
  logic iss_we, iss_own;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bcnt <= reset ? 0 : bus.mem_request ? cur_lat : bcnt != 0 ? bcnt - 1 : 0;
  assign bus.mem_busy = bcnt != 0;
  assign bus.mem_rdata = rd_val;
  typedef struct {
    bit d;
    bit we;
    logic [31:0] a;
    logic [7:0] wd;
    logic [7:0] rd;
    int lat;
    int exp_lat;
    logic [7:0] exp_wd;
    logic [7:0] exp_fr;
    logic [7:0] exp_dr;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [60:0] outs();
    return {bus.mem_request, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.f_ack, bus.d_ack, bus.f_rdata, bus.d_rdata, bus.owner};
  endfunction
  task automatic step;
    @(negedge clk);
    if (bus.mem_request) begin
      iss_cnt++;
      iss_cyc = cyc;
      iss_addr = bus.mem_addr;
      iss_we = bus.mem_we;
      iss_wd = bus.mem_wdata;
      iss_own = bus.owner;
    end
    fa_cnt += int'(bus.f_ack);
    da_cnt += int'(bus.d_ack);
  endtask
  task automatic clr;
    iss_cnt = 0;
    fa_cnt = 0;
    da_cnt = 0;
  endtask
  task automatic wait_ack(input bit d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step;
      if (d ? bus.d_ack : bus.f_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic do_reset;
    reset = 1'b1;
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (2) step;
    reset = 1'b0;
  endtask
  task automatic run_vec(input vec_t v, input string tag);
    int start;
    bit ok;
    step;
    chk({tag, " idle"}, {bus.mem_request, bus.mem_addr, bus.mem_we, bus.mem_wdata}, 0);
    clr;
    start = cyc;
    rd_val = v.rd;
    cur_lat = v.lat;
    if (v.d) begin
      bus.d_req = 1'b1;
      bus.d_we = v.we;
      bus.d_addr = v.a;
      bus.d_wdata = v.wd;
    end else begin
      bus.f_req = 1'b1;
      bus.f_addr = v.a;
    end
    wait_ack(v.d, ok);
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    chk({tag, " ack seen"}, ok, 1);
    chk({tag, " latency"}, cyc - start, v.exp_lat);
    chk({tag, " issues"}, iss_cnt, 1);
    chk({tag, " issue cycle"}, iss_cyc - start, 1);
    chk({tag, " mem_addr"}, iss_addr, v.a);
    chk({tag, " mem_we/wdata"}, {iss_we, iss_wd}, {v.d && v.we, v.exp_wd});
    chk({tag, " ack counts"}, {fa_cnt, da_cnt}, v.d ? {32'd0, 32'd1} : {32'd1, 32'd0});
    chk({tag, " rdata"}, {bus.f_rdata, bus.d_rdata}, {v.exp_fr, v.exp_dr});
    chk({tag, " owner"}, bus.owner, v.d);
  endtask
  initial begin
    int start;
    bit ok, got;
    bus.f_req = 1'b0;
    bus.f_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    tbl[0] = '{1'b0, 1'b0, 32'h10,       8'h00, 8'hA5, 2, 5, 8'h00, 8'hA5, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 32'h200,      8'h3C, 8'h77, 1, 4, 8'h3C, 8'hA5, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 32'h300,      8'h12, 8'h5E, 0, 3, 8'h12, 8'hA5, 8'h5E};
    tbl[3] = '{1'b0, 1'b0, 32'h0,        8'h00, 8'h11, 0, 3, 8'h00, 8'h11, 8'h5E};
    tbl[4] = '{1'b1, 1'b1, 32'h1234,     8'hFF, 8'h66, 3, 6, 8'hFF, 8'h11, 8'h5E};
    tbl[5] = '{1'b0, 1'b0, 32'hFFFFFFFF, 8'h00, 8'hC3, 1, 4, 8'h00, 8'hC3, 8'h5E};
    do_reset;
    chk("reset outputs", outs(), 0);
    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("v%0d", i));
    step;
    clr;
    bus.f_req = 1'b1;
    bus.f_addr = 32'h20;
    cur_lat = 5;
    rd_val = 8'hEE;
    step;
    step;
    chk("rst in wait", {bus.mem_request, bus.mem_addr, bus.mem_busy}, {1'b0, 32'h20, 1'b1});
    reset = 1'b1;
    bus.f_req = 1'b0;
    step;
    reset = 1'b0;
    chk("rst next cycle", outs(), 0);
    repeat (10) step;
    chk("rst no ack", {fa_cnt, da_cnt}, 0);
    chk("rst no reissue", iss_cnt, 1);
    run_vec(tbl[0], "post-reset fetch");
    step;
    clr;
    start = cyc;
    cur_lat = 0;
    rd_val = 8'h99;
    bus.f_req = 1'b1;
    bus.f_addr = 32'h4;
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h40;
    wait_ack(1'b1, ok);
    bus.d_req = 1'b0;
    chk("sim d ack", ok, 1);
    chk("sim d latency", cyc - start, 3);
    chk("sim d addr", iss_addr, 32'h40);
    chk("sim f still pending", fa_cnt, 0);
    wait_ack(1'b0, ok);
    bus.f_req = 1'b0;
    chk("sim f ack", ok, 1);
    chk("sim f latency", cyc - start, 7);
    chk("sim f addr", {iss_own, iss_addr}, {1'b0, 32'h4});
    chk("sim issues", iss_cnt, 2);
    do_reset;
    cur_lat = 0;
    bus.f_req = 1'b1;
    bus.f_addr = 32'h8;
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 32'h80;
    bus.d_wdata = 8'h01;
    for (int g = 0; g < 10; g++) begin
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        step;
        if (bus.mem_request) begin
          got = 1'b1;
          break;
        end
      end
      chk($sformatf("starve g%0d issue", g), got, 1);
      chk($sformatf("starve g%0d owner", g), bus.owner, (SG && g % 5 == 4) ? 0 : 1);
      for (int k = 0; k < 20; k++) begin
        step;
        if (bus.f_ack || bus.d_ack) break;
      end
    end
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    step;
    step;
    clr;
    cur_lat = 0;
    start = cyc;
    bus.f_req = 1'b1;
    bus.f_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      wait_ack(1'b0, ok);
      chk($sformatf("zw%0d ack", i), ok, 1);
      chk($sformatf("zw%0d ack cycle", i), cyc - start, 3 + 4 * i);
      chk($sformatf("zw%0d issue cycle", i), iss_cyc - start, 1 + 4 * i);
      chk($sformatf("zw%0d addr", i), iss_addr, i);
      bus.f_addr = i + 1;
    end
    bus.f_req = 1'b0;
    do_reset;
    begin
      bit fp = 0, dp = 0, dwe = 0, own = 0, w, inwin;
      logic [31:0] fa = 0, da = 0, la = 0;
      logic [7:0] dwd = 0, lwd = 0, ef = 0, ed = 0, rv = 0;
      bit lwe = 0;
      int iss = -100, ack = -100, scnt = 0, t;
      logic [60:0] e;
      for (int n = 0; n < 1500; n++) begin
        @(negedge clk);
        t = cyc;
        if (t == ack) begin
          if (!own) ef = rv;
          else if (!lwe) ed = rv;
        end
        inwin = t >= iss && t <= ack;
        e = {t == iss, inwin ? la : 32'h0, inwin && lwe, inwin ? lwd : 8'h0, t == ack && !own, t == ack && own, ef, ed, own};
        chk($sformatf("rand c%0d", t), outs(), e);
        if (t == ack) begin
          if (own) dp = 0;
          else fp = 0;
        end
        if (!fp && $urandom_range(0, 3) == 0) begin
          fp = 1;
          fa = $urandom;
        end
        if (!dp && $urandom_range(0, 3) == 0) begin
          dp = 1;
          da = $urandom;
          dwe = 1'($urandom_range(0, 1));
          dwd = 8'($urandom);
        end
        bus.f_req = fp;
        bus.f_addr = fa;
        bus.d_req = dp;
        bus.d_addr = da;
        bus.d_we = dwe;
        bus.d_wdata = dwd;
        if (t > ack && (fp || dp)) begin
          w = dp && !(fp && SG && scnt == LIMIT);
          scnt = !w ? 0 : fp && scnt < LIMIT ? scnt + 1 : scnt;
          own = w;
          la = w ? da : fa;
          lwe = w && dwe;
          lwd = w ? dwd : 8'h0;
          cur_lat = $urandom_range(0, 3);
          rv = 8'($urandom);
          rd_val = rv;
          iss = t + 1;
          ack = t + 3 + cur_lat;
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
